expr_result_sig_compactor: RTL and testbench

//  Downstream consumer of the 90-bit expression-block result bus y.

---
 rtl/expr_result_sig_compactor_pkg.sv | 18 +
 rtl/expr_result_sig_compactor_if.sv | 12 +
 rtl/expr_result_sig_compactor_misr_step.sv | 14 +
 rtl/expr_result_sig_compactor.sv | 88 ++++++++
 tb/tb_expr_result_sig_compactor.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/expr_result_sig_compactor_pkg.sv
// Shared types, widths and the result-bus fold used by the signature compactor.
package expr_regr_pkg;

   localparam int Y_W   = 90;
   localparam int SIG_W = 32;
   localparam int CNT_W = 16;

   localparam logic [SIG_W-1:0] DEF_POLY = 32'h04C11DB7;
   localparam logic [SIG_W-1:0] DEF_SEED = 32'hFFFFFFFF;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   // The upper slice is only 26 bits wide and is zero-extended before the XOR.
   function automatic logic [SIG_W-1:0] fold_y(input logic [Y_W-1:0] y);
      return y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]};
   endfunction

endpackage

// File: rtl/expr_result_sig_compactor_if.sv
// Valid/ready result-vector bus from the expression block into the compactor.
interface expr_result_sig_compactor_if;
   import expr_regr_pkg::*;

   logic           y_valid;
   logic           y_ready;
   logic [Y_W-1:0] y;

   modport master (output y_valid, output y, input y_ready);
   modport slave  (input y_valid, input y, output y_ready);

endinterface

// File: rtl/expr_result_sig_compactor_misr_step.sv
// Combinational fold of one result vector plus a single MISR shift/feedback step.
module expr_misr_step
   import expr_regr_pkg::*;
#(
   parameter logic [SIG_W-1:0] POLY = DEF_POLY
) (
   input  logic [SIG_W-1:0] sig,
   input  logic [Y_W-1:0]   y,
   output logic [SIG_W-1:0] sig_next
);

   assign sig_next = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ fold_y(y);

endmodule

// File: rtl/expr_result_sig_compactor.sv
// Compacts a programmed number of result vectors into a MISR signature and
// compares it with an expected value; done/pass are registered, y_ready/busy decode state.
module expr_result_sig_compactor
   import expr_regr_pkg::*;
#(
   parameter logic [SIG_W-1:0] POLY = DEF_POLY,
   parameter logic [SIG_W-1:0] SEED = DEF_SEED
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic [CNT_W-1:0]             num_vec,
   input  logic [SIG_W-1:0]             expect_sig,
   expr_result_sig_compactor_if.slave   ybus,
   output logic                         busy,
   output logic                         done,
   output logic                         pass,
   output logic [SIG_W-1:0]             signature,
   output logic [CNT_W-1:0]             vec_count
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] num_q;
   logic [SIG_W-1:0] exp_q;
   logic [SIG_W-1:0] sig_next;
   logic [CNT_W-1:0] cnt_inc;
   logic             accept;
   logic             last;
   logic             restart;

   expr_misr_step #(.POLY(POLY)) u_step (
      .sig      (signature),
      .y        (ybus.y),
      .sig_next (sig_next)
   );

   assign cnt_inc = vec_count + CNT_W'(1);

   always_comb begin
      state_d      = state_q;
      ybus.y_ready = 1'b0;
      busy         = 1'b0;
      accept       = 1'b0;
      last         = 1'b0;
      restart      = 1'b0;
      case (state_q)
         RUN: begin
            ybus.y_ready = 1'b1;
            busy         = 1'b1;
            accept       = ybus.y_valid;
            last         = accept && (cnt_inc == num_q);
            if (last) state_d = DONE;
         end
         default: begin
            // IDLE and DONE both restart identically on start
            restart = start;
            if (start) state_d = (num_vec == '0) ? DONE : RUN;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         done      <= 1'b0;
         pass      <= 1'b0;
         signature <= SEED;
         vec_count <= '0;
         num_q     <= '0;
         exp_q     <= '0;
      end else begin
         state_q <= state_d;
         done    <= (state_d == DONE);
         if (restart) begin
            signature <= SEED;
            vec_count <= '0;
            num_q     <= num_vec;
            exp_q     <= expect_sig;
            pass      <= (num_vec == '0) && (SEED == expect_sig);
         end else if (accept) begin
            signature <= sig_next;
            vec_count <= cnt_inc;
            if (last) pass <= (sig_next == exp_q);
         end
      end
   end

endmodule

// File: tb/tb_expr_result_sig_compactor.sv
// Directed and randomized checks of the signature compactor against a queue-based reference MISR.
module tb_expr_result_sig_compactor;
   import expr_regr_pkg::*;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [CNT_W-1:0] num_vec;
   logic [SIG_W-1:0] expect_sig;
   logic             busy, done, pass;
   logic [SIG_W-1:0] signature;
   logic [CNT_W-1:0] vec_count;

   expr_result_sig_compactor_if ybus ();

   expr_result_sig_compactor dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .num_vec    (num_vec),
      .expect_sig (expect_sig),
      .ybus       (ybus),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .signature  (signature),
      .vec_count  (vec_count)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   logic [Y_W-1:0] gen_q[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: polynomial shift in a 33-bit accumulator, reduce by x^32+POLY, add folded word.
   function automatic logic [SIG_W-1:0] model_sig();
      logic [32:0] acc;
      logic [31:0] s;
      logic [31:0] f;
      s = DEF_SEED;
      foreach (gen_q[i]) begin
         acc = {s, 1'b0};
         if (acc[32]) acc = acc ^ {1'b1, DEF_POLY};
         f = gen_q[i][31:0] ^ gen_q[i][63:32] ^ 32'(gen_q[i][89:64]);
         s = acc[31:0] ^ f;
      end
      return s;
   endfunction

   function automatic logic [Y_W-1:0] rand_y();
      logic [95:0] r;
      r = {$urandom, $urandom, $urandom};
      return r[Y_W-1:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int n, input logic [SIG_W-1:0] e);
      start      = 1'b1;
      num_vec    = CNT_W'(n);
      expect_sig = e;
      tick();
      start = 1'b0;
   endtask

   // Feeds gen_q[0..n-1]; mode 1 alternates valid starting high, mode 0 randomizes it.
   // A start pulse is injected on cycle inj (if >= 0) and must be ignored.
   task automatic feed(input int n, input int mode, input int inj, input string tag);
      int idx = 0;
      int cyc = 0;
      bit v;
      while (idx < n && cyc < 20 * n + 50) begin
         v = (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
         ybus.y_valid = v;
         ybus.y       = v ? gen_q[idx] : rand_y();
         if (cyc == inj) begin
            start   = 1'b1;
            num_vec = '0;
         end
         check({tag, "_ready"}, 64'(ybus.y_ready), 64'd1);
         tick();
         start = 1'b0;
         if (cyc == inj) begin
            check({tag, "_start_ignored_busy"}, 64'(busy), 64'd1);
            check({tag, "_start_ignored_cnt"}, 64'(vec_count), 64'(idx + int'(v)));
         end
         if (v) idx++;
         cyc++;
      end
      ybus.y_valid = 1'b0;
      if (idx < n) check({tag, "_timeout"}, 64'(idx), 64'(n));
   endtask

   task automatic run_check(input int n, input int mode, input bit good, input int inj, input string tag);
      logic [SIG_W-1:0] m;
      gen_q.delete();
      for (int i = 0; i < n; i++) gen_q.push_back(rand_y());
      m = model_sig();
      do_start(n, good ? m : (m ^ 32'h0000_0100));
      feed(n, mode, inj, tag);
      check({tag, "_done"}, 64'(done), 64'd1);
      check({tag, "_count"}, 64'(vec_count), 64'(n));
      check({tag, "_sig"}, 64'(signature), 64'(m));
      check({tag, "_pass"}, 64'(pass), 64'(good));
      check({tag, "_ready_after"}, 64'(ybus.y_ready), 64'd0);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_ready"}, 64'(ybus.y_ready), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd0);
      check({tag, "_pass"}, 64'(pass), 64'd0);
      check({tag, "_sig"}, 64'(signature), 64'(DEF_SEED));
      check({tag, "_count"}, 64'(vec_count), 64'd0);
   endtask

   task automatic single_zero_vector(input string tag);
      do_start(1, 32'hFB3EE249);
      ybus.y_valid = 1'b1;
      ybus.y       = '0;
      check({tag, "_busy"}, 64'(busy), 64'd1);
      check({tag, "_ready"}, 64'(ybus.y_ready), 64'd1);
      check({tag, "_not_done"}, 64'(done), 64'd0);
      tick();
      ybus.y_valid = 1'b0;
      check({tag, "_done"}, 64'(done), 64'd1);
      check({tag, "_sig"}, 64'(signature), 64'hFB3EE249);
      check({tag, "_pass"}, 64'(pass), 64'd1);
      check({tag, "_count"}, 64'(vec_count), 64'd1);
   endtask

   initial begin
      reset        = 1'b1;
      start        = 1'b0;
      num_vec      = '0;
      expect_sig   = '0;
      ybus.y_valid = 1'b0;
      ybus.y       = '0;
      tick();
      check_reset_vals("reset");
      reset = 1'b0;
      tick();

      // IDLE ignores y_valid
      ybus.y_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         ybus.y = rand_y();
         tick();
      end
      ybus.y_valid = 1'b0;
      check("idle_ready", 64'(ybus.y_ready), 64'd0);
      check("idle_count", 64'(vec_count), 64'd0);
      check("idle_sig", 64'(signature), 64'(DEF_SEED));

      single_zero_vector("t1");

      do_start(0, 32'hFFFFFFFF);
      check("t2_done", 64'(done), 64'd1);
      check("t2_count", 64'(vec_count), 64'd0);
      check("t2_pass", 64'(pass), 64'd1);
      check("t2_busy", 64'(busy), 64'd0);
      do_start(0, 32'h0);
      check("t2b_done", 64'(done), 64'd1);
      check("t2b_pass", 64'(pass), 64'd0);

      // valid pattern 1,0,1,0,1,0,1 gives exactly four accepts
      run_check(4, 1, 1'b1, -1, "t3");
      ybus.y_valid = 1'b1;
      ybus.y       = rand_y();
      tick();
      ybus.y_valid = 1'b0;
      check("t3_extra_count", 64'(vec_count), 64'd4);
      check("t3_extra_sig", 64'(signature), 64'(model_sig()));

      // reset mid-run after two accepts
      do_start(5, 32'h1234_5678);
      ybus.y_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         ybus.y = rand_y();
         tick();
      end
      ybus.y_valid = 1'b0;
      check("t5_mid_count", 64'(vec_count), 64'd2);
      reset = 1'b1;
      #1;
      check_reset_vals("t5_async");
      tick();
      reset = 1'b0;
      tick();
      single_zero_vector("t5_rerun");

      // start in RUN ignored; start in DONE restarts
      run_check(3, 0, 1'b1, 1, "t6");
      do_start(2, 32'h0);
      check("t6_restart_done", 64'(done), 64'd0);
      check("t6_restart_count", 64'(vec_count), 64'd0);
      check("t6_restart_busy", 64'(busy), 64'd1);
      check("t6_restart_sig", 64'(signature), 64'(DEF_SEED));
      gen_q.delete();
      for (int i = 0; i < 2; i++) gen_q.push_back(rand_y());
      feed(2, 0, -1, "t6_run2");
      check("t6_run2_sig", 64'(signature), 64'(model_sig()));
      check("t6_run2_pass", 64'(pass), 64'(model_sig() == 32'h0));

      for (int k = 0; k < 8; k++) begin
         run_check(int'($urandom_range(1, 24)), 0, 1'($urandom_range(0, 1)), -1, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
